// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the serializer/deserializer family.
`timescale 1ns/1ps
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_WIDTH = 16;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter with clear, enable and selectable direction.
// Up mode counts 0..TC_VAL; down mode counts TC_VAL..0. tc flags the terminal value.
`timescale 1ns/1ps
module ser_bit_counter #(
    parameter int                 CNT_W  = 4,
    parameter logic [CNT_W-1:0]   TC_VAL = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic up,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= up ? '0 : TC_VAL;
        end else if (en) begin
            cnt <= up ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
        end
    end

    assign tc = up ? (cnt == TC_VAL) : (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out frame serializer with valid/ready load port.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
`timescale 1ns/1ps
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             hold,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    piso_state_t      state, state_next;
    logic [WIDTH-1:0] shadow, shadow_next;
    logic             sout_next;
    logic             done_next;
    logic             handshake;
    logic             shift_en;
    logic             last_bit;

    assign handshake = load_valid && load_ready;
    assign shift_en  = (state == SHIFT) && !hold;

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Parity is taken from the word as captured, so later upstream changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (handshake) begin
            parity_q <= ^load_data;
        end
    end

    assign sout_en = ((state == SHIFT) || (state == PARITY)) && !hold;
`else
    assign sout_en = (state == SHIFT) && !hold;
`endif

    // Clearing on the final shift leaves the counter at 0 for the next frame.
    ser_bit_counter #(
        .CNT_W  (CW),
        .TC_VAL (LAST)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (shift_en && last_bit),
        .en    (shift_en),
        .up    (1'b1),
        .tc    (last_bit)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        done_next   = 1'b0;
        sout_next   = 1'b0;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next  = SHIFT;
                    shadow_next = load_data;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    shadow_next = shadow >> 1;
                    if (last_bit) begin
`ifdef PISO_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        done_next  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (!hold) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Outputs are registered from next-state values, so sout is a clean flop.
        if (state_next == SHIFT) begin
            sout_next = shadow_next[0];
        end
`ifdef PISO_PARITY_EN
        else if (state_next == PARITY) begin
            sout_next = parity_q;
        end
`endif
    end

    // NOTE: the shadow register is reset too, so an aborted frame leaves no stale bits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            sout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_next;
            shadow     <= shadow_next;
            sout       <= sout_next;
            busy       <= (state_next != IDLE);
            done       <= done_next;
            load_ready <= (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (WIDTH=16), aware of PISO_PARITY_EN.
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int          PAR   = 1;
    localparam logic [4:0]  EXP_Q = 5'b00001;
`else
    localparam int          PAR   = 0;
    localparam logic [4:0]  EXP_Q = 5'b00010;
`endif
    localparam int F = W + PAR + 1;

    // Observed outputs packed as {sout, sout_en, busy, load_ready, done}.
    localparam logic [4:0] IDLE_OBS = 5'b00010;
    localparam logic [4:0] DONE_OBS = 5'b00011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         load_valid = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready, sout, sout_en, busy, done;
    logic [4:0]   obs;
    logic [0:3]   q;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] seq;      // expected bits in transmission order, first bit at MSB
        logic         par;
        int           hold_c;   // first held cycle after the handshake
        int           hold_len;
        int           exp_done; // done cycle without parity
    } vec_t;

    vec_t vecs[6];

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .hold       (hold),
        .sout       (sout),
        .sout_en    (sout_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign obs = {sout, sout_en, busy, load_ready, done};

    // Downstream 4-bit serial-in shift register, q[0] takes the newest bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (sout_en) q <= {sout, q[0:2]};
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v, input bit scramble);
        int   bit_i;
        int   last_c;
        bit   held;
        logic b;
        bit_i  = 0;
        last_c = v.exp_done + PAR;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = v.data;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            held = (v.hold_len > 0) && (c >= v.hold_c) && (c < v.hold_c + v.hold_len);
            hold = held;
            if (scramble) load_data = W'($urandom);
            @(negedge clk);
            if (c == last_c) begin
                check($sformatf("v%0d c%0d done", idx, c), obs, DONE_OBS);
            end else begin
                b = (bit_i < W) ? v.seq[W-1-bit_i] : v.par;
                check($sformatf("v%0d c%0d bit%0d", idx, c, bit_i), obs,
                      {b, !held, 1'b1, 1'b0, 1'b0});
                if (!held) bit_i++;
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
    endtask

    initial begin
        logic [W-1:0] word;
        logic [4:0]   exp;
        int           r;
        bit           seen;

        vecs[0] = '{16'h2E7B, 16'b1101_1110_0111_0100, 1'b0,  0, 0, 17};
        vecs[1] = '{16'h2E7B, 16'b1101_1110_0111_0100, 1'b0,  6, 3, 20};
        vecs[2] = '{16'hA5C3, 16'b1100_0011_1010_0101, 1'b0,  0, 0, 17};
        vecs[3] = '{16'h8000, 16'h0001,                1'b1,  0, 0, 17};
        vecs[4] = '{16'h0001, 16'h8000,                1'b1, 16, 2, 19};
        vecs[5] = '{16'hFFFF, 16'hFFFF,                1'b0,  0, 0, 17};

        // Asynchronous reset, before any clock edge has been seen.
        #2 rst_n = 1'b0;
        #1 check("reset_async", obs, IDLE_OBS);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check("reset_idle", obs, IDLE_OBS);

        run_vec(0, vecs[0], 1'b0);
        check("downstream_q", {1'b0, q}, EXP_Q);
        for (int i = 1; i < 6; i++) run_vec(i, vecs[i], 1'b0);

        // Upstream data churns every cycle during the frame.
        run_vec(6, vecs[2], 1'b1);

        // Back-to-back frames with load_valid held high throughout.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        @(posedge clk);
        #1 load_data = 16'h0001;
        for (int c = 1; c <= 2 * F; c++) begin
            @(negedge clk);
            r    = (c > F) ? c - F : c;
            word = (c > F) ? 16'h0001 : 16'hFFFF;
            if (r == F)       exp = DONE_OBS;
            else if (r <= W)  exp = {word[r-1], 4'b1100};
            else              exp = {^word, 4'b1100};
            check($sformatf("b2b c%0d", c), obs, exp);
            @(posedge clk);
            #1;
            if (c == F) load_valid = 1'b0;
        end

        // Reset pulsed during bit 7 abandons the frame.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'h2E7B;
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("midframe_reset", obs, IDLE_OBS);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_done_after_reset", {4'b0, seen}, 5'b0);
        check("idle_after_reset", obs, IDLE_OBS);
        run_vec(7, vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out frame serializer: accepts a WIDTH-bit word on a valid/ready handshake and emits it LSB-first, one bit per clock, with a qualifying strobe. It sits directly upstream of the 4-bit serial-in shift register. `sout` drives that register's serial input and `sout_en` drives its shift enable, so each strobed bit shifts in exactly once.

## Interface
- `WIDTH`, 16: data bits per frame; legal range 2..64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream word available.
- `load_ready`  out  1  block can accept a word.
- `load_data`  in  WIDTH  word to serialize; sampled only on a handshake.
- `hold`  in  1  stall request; freezes shifting while high.
- `sout`  out  1  serial data bit.
- `sout_en`  out  1  `sout` is valid this cycle and must be consumed.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the final bit of a frame.

## Operation
- Reset values: `sout`=0, `sout_en`=0, `load_ready`=1, `busy`=0, `done`=0, state IDLE, counter 0.
- **IDLE**
  - `load_ready`=1.
  - A handshake (`load_valid`&`load_ready` at a rising edge) captures `load_data` into an internal shift register and moves the block to SHIFT.
- **SHIFT**
  - `sout` = shadow[0] and `busy`=1.
  - `sout_en` = !`hold`.
  - On each edge with `hold`=0: shift right by one and increment the counter.
  - When the counter reaches WIDTH-1 and `hold`=0: go to IDLE, or to PARITY when that option is compiled in.
- **PARITY** (option only)
  - `sout` = XOR of the captured word (even parity).
  - `sout_en` = !`hold`.
  - Leaves for IDLE on the first edge with `hold`=0.
- **done**
  - Asserted for exactly one cycle: the first IDLE cycle after a completed frame.
- **sout when not strobed**
  - Outside SHIFT/PARITY, `sout` is held at 0.
  - While `hold`=1, `sout` holds its current bit, and `sout_en`=0.
- **Word capture**
  - `load_data` is ignored except at the handshake edge.
  - Upstream changes during a frame have no effect.
- **Reset mid-frame:** abandons the frame, restores all reset values, and produces no `done` pulse.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs except `sout_en` from `hold`.
- Latency: the handshake at edge N puts bit 0 on `sout` with `sout_en`=1 during cycle N+1.
- With `hold` tied low:
  - Bit k appears in cycle N+1+k.
  - The last data bit appears in cycle N+WIDTH.
  - `done`=1 and `load_ready`=1 in cycle N+WIDTH+1.
- Minimum frame period is WIDTH+1 cycles (WIDTH+2 with parity), because one IDLE bubble separates frames.
- `load_ready` is low for every SHIFT/PARITY cycle. A `load_valid` asserted then waits and is not lost.
- `hold` asserted in the last-bit cycle delays completion; `done` follows the first un-held edge of that bit.
- Simultaneous handshake and `done` cycle is legal: that edge captures the new word, and the next cycle is bit 0 of the new frame.

## Configuration
- `PISO_PARITY_EN` defined:
  - One extra strobed bit (even parity of the word) follows the data bits.
  - Frame length is WIDTH+1 strobed bits.
  - `done` shifts one cycle later.
- `PISO_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Exactly WIDTH strobed bits per frame.

## Structure
- Package `serdes_pkg`:
  - State typedef `piso_state_t` {IDLE, SHIFT, PARITY}.
  - Function `cnt_w(WIDTH)` = $clog2(WIDTH).
  - Localparam default `PISO_WIDTH`=16.
- One natural sub-module, `ser_bit_counter`:
  - Parameterized down/up counter with clear, enable and terminal-count output.
  - Reusable by the future deserializer.
- All other logic stays in `piso_serializer`.

## Test plan
- Reset then handshake with `load_data`=16'b0010_1110_0111_1011, `hold`=0:
  - `sout` over cycles 1..16 = 1,1,0,1,1,1,1,0,0,1,1,1,0,1,0,0 with `sout_en`=1 throughout.
  - `done` pulses in cycle 17.
  - A downstream 4-bit shift register ends with q[0:3]=0010.
- Same word with `PISO_PARITY_EN`: cycle 17 gives `sout`=0 (ten ones) with `sout_en`=1, and `done` pulses in cycle 18.
- `hold` high for 3 cycles at bit 5:
  - `sout_en`=0 and `sout` stable for those cycles.
  - The bit sequence is unchanged.
  - `done` arrives 3 cycles late.
- `load_valid` held high continuously with two words: 16'hFFFF and 16'h0001 back-to-back, one-cycle bubble, second frame starting in cycle 18, `load_ready` low during both frames.
- `rst_n` pulsed low during bit 7:
  - Outputs return to reset values asynchronously.
  - No `done`.
  - The next handshake starts a clean frame from bit 0.
- Change `load_data` every cycle during a frame: the serialized bits match only the word captured at the handshake.
